uart_rx: RTL and testbench

Serial-to-parallel UART receiver and the receive-side companion to `uart_tx`: both share the same frame format parameters and baud arithmetic. It synchronises the asynchronous `i_rx` line and detects the start bit. It samples each bit at mid-bit, checks optional parity and the stop bit(s), and presents each received word through a valid/acknowledge handshake with parity, framing and overrun error flags.

---
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// uart_rx: two-flop synchronised UART receiver with mid-bit sampling, optional parity,
// 1/2 stop bits and a valid/ack output handshake with parity, framing and overrun flags.
module uart_rx #(
  parameter int    WORD_LENGTH = 8,
  parameter string PARITY      = "none",
  parameter int    STOP_BITS   = 1,
  parameter int    BAUD_RATE   = 9600,
  parameter int    CLK_FREQ    = 50_000_000
) (
  input  logic                   clk_glb,
  input  logic                   rst_n,
  input  logic                   i_rx,
  input  logic                   rx_ack,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_busy,
  output logic                   rx_parity_err,
  output logic                   rx_frame_err,
  output logic                   rx_overrun
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int          HALF         = CLKS_PER_BIT / 2;
  localparam logic [31:0] CPB_M1       = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_M1      = 32'(HALF - 1);
  localparam logic [3:0]  DATA_LAST    = 4'(WORD_LENGTH - 1);
  localparam logic [3:0]  STOP_LAST    = 4'(STOP_BITS - 1);
  localparam bit          HAS_PAR      = (PARITY != "none");
  localparam bit          ODD_PAR      = (PARITY == "odd");

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                   r_sync1;
  logic                   r_rx_s;
  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [31:0]            r_cnt;
  logic [3:0]             r_bitcnt;
  logic [WORD_LENGTH-1:0] r_shift;
  logic                   r_par_pend;
  logic                   r_frm_pend;
  logic                   r_armed;
  logic                   r_done;
  logic                   w_tick;
  logic                   w_start_det;
  logic                   w_last_stop;
  logic                   w_busy;

  always_ff @(posedge clk_glb or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_det) w_next = S_START;
      S_START:  if (w_tick) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_tick && r_bitcnt == DATA_LAST) w_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_next = S_STOP;
      S_STOP:   if (w_tick && r_bitcnt == STOP_LAST) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The cycle that detects the start edge is the first cycle of the half-bit wait.
  always_comb begin
    w_tick      = 1'b0;
    w_start_det = 1'b0;
    w_last_stop = 1'b0;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:                   w_start_det = !r_rx_s && r_armed;
      S_START:                  w_tick = (r_cnt == HALF_M1);
      S_DATA, S_PARITY, S_STOP: w_tick = (r_cnt == CPB_M1);
      default:                  w_tick = 1'b0;
    endcase
    w_last_stop = (r_state == S_STOP) && w_tick && (r_bitcnt == STOP_LAST);
  end

  assign rx_busy = w_busy;

  always_ff @(posedge clk_glb or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_rx_s     <= 1'b1;
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
      r_armed    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
      r_done  <= w_last_stop;

      if (r_state == S_IDLE)  r_cnt <= w_start_det ? 32'd1 : 32'd0;
      else if (w_tick)        r_cnt <= '0;
      else                    r_cnt <= r_cnt + 32'd1;

      if (r_state != w_next)  r_bitcnt <= '0;
      else if (w_tick)        r_bitcnt <= r_bitcnt + 4'd1;

      if (r_state == S_DATA && w_tick) r_shift <= {r_rx_s, r_shift[WORD_LENGTH-1:1]};

      if (w_start_det) begin
        r_par_pend <= 1'b0;
        r_frm_pend <= 1'b0;
      end
      if (r_state == S_PARITY && w_tick) r_par_pend <= ((^r_shift) ^ r_rx_s) != ODD_PAR;
      if (r_state == S_STOP && w_tick && !r_rx_s) r_frm_pend <= 1'b1;

      // A frame ending on a low line (break) must not re-trigger until the line idles.
      if (w_last_stop && !r_rx_s) r_armed <= 1'b0;
      else if (r_rx_s)            r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_glb or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (r_done) begin
      rx_data       <= r_shift;
      rx_parity_err <= r_par_pend;
      rx_frame_err  <= r_frm_pend;
      rx_valid      <= 1'b1;
      if (rx_valid && !rx_ack) rx_overrun <= 1'b1;
      else if (rx_valid)       rx_overrun <= 1'b0;
    end else if (rx_ack && rx_valid) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx: scoreboard bench for uart_rx (8N1, 8E1 and 8N2 instances at 10 clocks per bit).
module tb_uart_rx;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx   [3];
  logic       ack  [3];
  logic [7:0] dat  [3];
  logic       val  [3];
  logic       busy [3];
  logic       pe   [3];
  logic       fe   [3];
  logic       ov   [3];
  logic       pv   [3];
  logic       po   [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_vec = 0;
  int n_err = 0;

  uart_rx #(.WORD_LENGTH(8), .PARITY("none"), .STOP_BITS(1),
            .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)) u_n1 (
    .clk_glb(clk), .rst_n(rst_n), .i_rx(rx[0]), .rx_ack(ack[0]),
    .rx_data(dat[0]), .rx_valid(val[0]), .rx_busy(busy[0]),
    .rx_parity_err(pe[0]), .rx_frame_err(fe[0]), .rx_overrun(ov[0]));

  uart_rx #(.WORD_LENGTH(8), .PARITY("even"), .STOP_BITS(1),
            .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)) u_e1 (
    .clk_glb(clk), .rst_n(rst_n), .i_rx(rx[1]), .rx_ack(ack[1]),
    .rx_data(dat[1]), .rx_valid(val[1]), .rx_busy(busy[1]),
    .rx_parity_err(pe[1]), .rx_frame_err(fe[1]), .rx_overrun(ov[1]));

  uart_rx #(.WORD_LENGTH(8), .PARITY("none"), .STOP_BITS(2),
            .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)) u_n2 (
    .clk_glb(clk), .rst_n(rst_n), .i_rx(rx[2]), .rx_ack(ack[2]),
    .rx_data(dat[2]), .rx_valid(val[2]), .rx_busy(busy[2]),
    .rx_parity_err(pe[2]), .rx_frame_err(fe[2]), .rx_overrun(ov[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic p, input logic f, input logic o);
    exp_t e;
    e.d = d; e.pe = p; e.fe = f; e.ov = o;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int id);
    exp_t e;
    int   sz;
    case (id)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_frame dut%0d: got data 0x%0h, expected no frame", id, dat[id]);
    end else begin
      case (id)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("dut%0d data", id),       32'(dat[id]), 32'(e.d));
      chk($sformatf("dut%0d parity_err", id), 32'(pe[id]),  32'(e.pe));
      chk($sformatf("dut%0d frame_err", id),  32'(fe[id]),  32'(e.fe));
      chk($sformatf("dut%0d overrun", id),    32'(ov[id]),  32'(e.ov));
    end
  endtask

  // Monitor: a new word shows up as rx_valid rising, or rx_overrun rising while valid.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && ((val[i] && !pv[i]) || (ov[i] && !po[i]))) mon(i);
      pv[i] <= val[i];
      po[i] <= ov[i];
    end
  end

  task automatic drive_bit(input int id, input logic b);
    rx[id] = b;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [7:0] d, input int par,
                      input int nstop, input logic s1, input logic s2);
    drive_bit(id, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(id, d[i]);
    if (par >= 0) drive_bit(id, par[0]);
    drive_bit(id, s1);
    if (nstop == 2) drive_bit(id, s2);
    rx[id] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input int id);
    ack[id] = 1'b1;
    idle(1);
    ack[id] = 1'b0;
    chk($sformatf("dut%0d valid_after_ack", id), 32'(val[id]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx[i] = 1'b1; ack[i] = 1'b0; pv[i] = 1'b0; po[i] = 1'b0;
    end
    idle(3);
    chk("reset data",      32'(dat[0]), 32'd0);
    chk("reset valid",     32'(val[0]), 32'd0);
    chk("reset busy",      32'(busy[0]), 32'd0);
    chk("reset flags",     32'({pe[0], fe[0], ov[0]}), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // 8N1 0xA5: latency from falling edge to valid
    push(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    lat = 0;
    fork
      send(0, 8'hA5, -1, 1, 1'b1, 1'b1);
      begin
        for (int n = 1; n <= 200; n++) begin
          @(posedge clk);
          #1;
          if (val[0] && lat == 0) lat = n;
        end
      end
    join_any
    chk("latency_edges", 32'(lat), 32'd98);
    idle(2);
    do_ack(0);
    idle(20);

    // even parity: correct then wrong parity bit
    push(1, 8'h03, 1'b0, 1'b0, 1'b0);
    send(1, 8'h03, 0, 1, 1'b1, 1'b1);
    do_ack(1);
    idle(10);
    push(1, 8'h03, 1'b1, 1'b0, 1'b0);
    send(1, 8'h03, 1, 1, 1'b1, 1'b1);
    do_ack(1);
    idle(10);

    // framing errors on 1 and 2 stop bits, then a clean 2-stop frame
    push(0, 8'h5A, 1'b0, 1'b1, 1'b0);
    send(0, 8'h5A, -1, 1, 1'b0, 1'b1);
    idle(10);
    do_ack(0);
    push(2, 8'h5A, 1'b0, 1'b1, 1'b0);
    send(2, 8'h5A, -1, 2, 1'b1, 1'b0);
    idle(10);
    do_ack(2);
    push(2, 8'hC3, 1'b0, 1'b0, 1'b0);
    send(2, 8'hC3, -1, 2, 1'b1, 1'b1);
    do_ack(2);
    idle(20);

    // 3-cycle glitch is a false start
    rx[0] = 1'b0;
    idle(3);
    rx[0] = 1'b1;
    idle(30);
    chk("glitch valid", 32'(val[0]), 32'd0);
    chk("glitch busy",  32'(busy[0]), 32'd0);

    // back-to-back without ack -> overrun
    push(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    push(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send(0, 8'h3C, -1, 1, 1'b1, 1'b1);
    send(0, 8'h3C, -1, 1, 1'b1, 1'b1);
    ack[0] = 1'b1;
    idle(1);
    ack[0] = 1'b0;
    chk("overrun valid_after_ack", 32'(val[0]), 32'd0);
    chk("overrun cleared",         32'(ov[0]), 32'd0);
    idle(20);

    // async reset mid-frame
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rx[0] = 1'b1;
    idle(3);
    chk("midframe busy", 32'(busy[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst busy",   32'(busy[0]), 32'd0);
    chk("async_rst data",   32'(dat[0]), 32'd0);
    chk("async_rst perr1",  32'(pe[1]), 32'd0);
    #1 rst_n = 1'b1;
    idle(20);
    push(0, 8'h81, 1'b0, 1'b0, 1'b0);
    send(0, 8'h81, -1, 1, 1'b1, 1'b1);
    do_ack(0);
    idle(20);

    // break: one flagged zero frame, no re-trigger while low
    push(0, 8'h00, 1'b0, 1'b1, 1'b0);
    rx[0] = 1'b0;
    idle(200);
    chk("break no_retrigger busy", 32'(busy[0]), 32'd0);
    idle(100);
    do_ack(0);
    rx[0] = 1'b1;
    idle(50);
    chk("break after valid", 32'(val[0]), 32'd0);
    chk("break after busy",  32'(busy[0]), 32'd0);

    chk("pending q0", 32'(q0.size()), 32'd0);
    chk("pending q1", 32'(q1.size()), 32'd0);
    chk("pending q2", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
